// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// register address type and the write-port priority picker used by both the
// array write path and the read bypass.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Upper bound on write ports handled by the priority picker.
    localparam int MAX_WR = 8;
    localparam int PORT_W = 3;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

    typedef struct packed {
        logic              found;
        logic [PORT_W-1:0] port;
    } wr_win_t;

    // Given a mask of write ports hitting one address, return the winner.
    // Later iterations overwrite earlier ones, so the highest index wins.
    function automatic wr_win_t pick_write_port(input logic [MAX_WR-1:0] hit);
        wr_win_t w;
        w = '0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (hit[j]) begin
                w.found = 1'b1;
                w.port  = PORT_W'(j);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register plus a
// registered count of set bits, maintained incrementally from the next state.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic [NREGS-1:0] clr,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_count
);

    localparam int CW = AW + 1;

    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    set_cnt;
    logic [CW-1:0]    clr_cnt;
    logic [CW-1:0]    count_nxt;

    // Next busy vector: issue wins over a same-cycle clear, r0 never busy.
    always_comb begin
        busy_nxt = busy;
        set_cnt  = '0;
        clr_cnt  = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy_nxt[r] = (issue_en && (issue_addr == AW'(r))) || (busy[r] && !clr[r]);
        end
        busy_nxt[0] = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (busy_nxt[r] && !busy[r]) set_cnt = set_cnt + CW'(1);
            if (busy[r] && !busy_nxt[r]) clr_cnt = clr_cnt + CW'(1);
        end
        count_nxt = busy_count + set_cnt - clr_cnt;
    end

    // Busy vector and count register; reset clears everything at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with hardwired r0 and a pending-write
// scoreboard. Optional same-cycle write-to-read bypass: REGFILE_BYPASS_EN.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    parameter  int NWR   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NRD-1:0][AW-1:0]    ReadAddr,
    output logic [NRD-1:0][XLEN-1:0]  ReadData,
    output logic [NRD-1:0]            ReadBusy,
    input  logic [NWR-1:0]            WriteEn,
    input  logic [NWR-1:0][AW-1:0]    WriteAddr,
    input  logic [NWR-1:0][XLEN-1:0]  WriteData,
    input  logic                      IssueEn,
    input  logic [AW-1:0]             IssueAddr,
    output logic [AW:0]               BusyCount
);

    logic [XLEN-1:0]  mem    [NREGS];
    logic [XLEN-1:0]  wr_val [NREGS];
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] busy;

    // Data of the write port selected by the priority picker.
    function automatic logic [XLEN-1:0] wr_data_of(input logic [PORT_W-1:0] p);
        logic [XLEN-1:0] v;
        v = '0;
        for (int j = 0; j < NWR; j++) begin
            if (p == PORT_W'(j)) v = WriteData[j];
        end
        return v;
    endfunction

    // Ports (up to MAX_WR) hitting a given address this cycle.
    function automatic logic [MAX_WR-1:0] wr_hits(input logic [AW-1:0] a);
        logic [MAX_WR-1:0] h;
        h = '0;
        for (int j = 0; j < NWR; j++) begin
            h[j] = WriteEn[j] && (WriteAddr[j] == a);
        end
        return h;
    endfunction

    // Per-register write resolution; r0 is never a target.
    always_comb begin
        wr_win_t w;
        for (int r = 0; r < NREGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            w = pick_write_port(wr_hits(AW'(r)));
            if (w.found && (r != 0)) begin
                wr_hit[r] = 1'b1;
                wr_val[r] = wr_data_of(w.port);
            end
        end
    end

    // Data array; mem[0] is only ever cleared so it stays zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr_hit[r]) mem[r] <= wr_val[r];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .rstn       (rstn),
        .issue_en   (IssueEn),
        .issue_addr (IssueAddr),
        .clr        (wr_hit),
        .busy       (busy),
        .busy_count (BusyCount)
    );

    // Combinational read ports, with optional same-cycle write forwarding.
    always_comb begin
        logic [AW-1:0] a;
        wr_win_t       bw;
        for (int i = 0; i < NRD; i++) begin
            a           = ReadAddr[i];
            ReadData[i] = mem[a];
            ReadBusy[i] = busy[a];
            bw          = pick_write_port(wr_hits(a));
            if (a == '0) begin
                ReadData[i] = '0;
                ReadBusy[i] = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (bw.found) begin
                ReadData[i] = wr_data_of(bw.port);
                ReadBusy[i] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport (default geometry).
module tb_regfile_multiport;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic                   clk;
    logic                   rstn;
    logic [1:0][AW-1:0]     ReadAddr;
    logic [1:0][XLEN-1:0]   ReadData;
    logic [1:0]             ReadBusy;
    logic [1:0]             WriteEn;
    logic [1:0][AW-1:0]     WriteAddr;
    logic [1:0][XLEN-1:0]   WriteData;
    logic                   IssueEn;
    logic [AW-1:0]          IssueAddr;
    logic [AW:0]            BusyCount;

    int errors = 0;
    int checks = 0;

    regfile_multiport dut (
        .clk       (clk),
        .rstn      (rstn),
        .ReadAddr  (ReadAddr),
        .ReadData  (ReadData),
        .ReadBusy  (ReadBusy),
        .WriteEn   (WriteEn),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .IssueEn   (IssueEn),
        .IssueAddr (IssueAddr),
        .BusyCount (BusyCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WriteEn = 2'b00;
        IssueEn = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        ReadAddr  = '0;
        WriteEn   = '0;
        WriteAddr = '0;
        WriteData = '0;
        IssueEn   = 1'b0;
        IssueAddr = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state on every address
        for (int a = 0; a < 32; a++) begin
            ReadAddr[0] = AW'(a);
            ReadAddr[1] = AW'(31 - a);
            #1;
            chk("rst_data0", 64'(ReadData[0]), 64'd0);
            chk("rst_data1", 64'(ReadData[1]), 64'd0);
            chk("rst_busy", 64'(ReadBusy), 64'd0);
        end
        chk("rst_count", 64'(BusyCount), 64'd0);

        @(negedge clk);
        rstn = 1'b1;
        #1;

        // Two ports, two addresses
        WriteEn      = 2'b11;
        WriteAddr[0] = 5'd5;  WriteData[0] = 32'd50;
        WriteAddr[1] = 5'd10; WriteData[1] = 32'd30;
        tick();
        idle();
        ReadAddr[0] = 5'd5; ReadAddr[1] = 5'd10;
        #1;
        chk("wr_r5", 64'(ReadData[0]), 64'd50);
        chk("wr_r10", 64'(ReadData[1]), 64'd30);

        // Same-address conflict: port 1 wins
        WriteEn      = 2'b11;
        WriteAddr[0] = 5'd7; WriteData[0] = 32'h11;
        WriteAddr[1] = 5'd7; WriteData[1] = 32'h22;
        tick();
        idle();
        ReadAddr[0] = 5'd7;
        #1;
        chk("conflict_r7", 64'(ReadData[0]), 64'h22);

        // Write to r0 is ignored
        WriteEn      = 2'b01;
        WriteAddr[0] = 5'd0; WriteData[0] = 32'hFF;
        tick();
        idle();
        ReadAddr[0] = 5'd0;
        #1;
        chk("r0_data", 64'(ReadData[0]), 64'd0);
        chk("r0_busy", 64'(ReadBusy[0]), 64'd0);

        // Issue r3 then r4
        IssueEn = 1'b1; IssueAddr = 5'd3;
        tick();
        IssueAddr = 5'd4;
        tick();
        idle();
        ReadAddr[0] = 5'd3; ReadAddr[1] = 5'd4;
        #1;
        chk("issue_count2", 64'(BusyCount), 64'd2);
        chk("issue_busy_r3", 64'(ReadBusy[0]), 64'd1);
        chk("issue_busy_r4", 64'(ReadBusy[1]), 64'd1);

        // Re-issue of a busy register
        IssueEn = 1'b1; IssueAddr = 5'd3;
        tick();
        idle();
        #1;
        chk("reissue_count", 64'(BusyCount), 64'd2);

        // Write and issue r3 together: stays busy
        IssueEn = 1'b1; IssueAddr = 5'd3;
        WriteEn = 2'b01; WriteAddr[0] = 5'd3; WriteData[0] = 32'h333;
        tick();
        idle();
        #1;
        chk("wi_busy_r3", 64'(ReadBusy[0]), 64'd1);
        chk("wi_count", 64'(BusyCount), 64'd2);
        chk("wi_data_r3", 64'(ReadData[0]), 64'h333);

        // Write r4 alone clears it
        WriteEn = 2'b10; WriteAddr[1] = 5'd4; WriteData[1] = 32'h444;
        tick();
        idle();
        #1;
        chk("clr_count", 64'(BusyCount), 64'd1);
        chk("clr_busy_r4", 64'(ReadBusy[1]), 64'd0);

        // Issue to r0 is ignored
        IssueEn = 1'b1; IssueAddr = 5'd0;
        tick();
        idle();
        ReadAddr[1] = 5'd0;
        #1;
        chk("issue_r0_count", 64'(BusyCount), 64'd1);
        chk("issue_r0_busy", 64'(ReadBusy[1]), 64'd0);

        // Clear r3 and set r6 in one edge: count unchanged
        IssueEn = 1'b1; IssueAddr = 5'd6;
        WriteEn = 2'b01; WriteAddr[0] = 5'd3; WriteData[0] = 32'h3333;
        tick();
        idle();
        ReadAddr[0] = 5'd3; ReadAddr[1] = 5'd6;
        #1;
        chk("swap_count", 64'(BusyCount), 64'd1);
        chk("swap_busy_r3", 64'(ReadBusy[0]), 64'd0);
        chk("swap_busy_r6", 64'(ReadBusy[1]), 64'd1);

        // Prepare r9 = 0x1234, busy
        WriteEn = 2'b01; WriteAddr[0] = 5'd9; WriteData[0] = 32'h1234;
        tick();
        idle();
        IssueEn = 1'b1; IssueAddr = 5'd9;
        tick();
        idle();
        ReadAddr[0] = 5'd9; ReadAddr[1] = 5'd0;
        #1;
        chk("pre_bp_count", 64'(BusyCount), 64'd2);

        // Same-cycle read of a register being written; r0 never forwarded
        WriteEn = 2'b11;
        WriteAddr[0] = 5'd0; WriteData[0] = 32'h55;
        WriteAddr[1] = 5'd9; WriteData[1] = 32'hABCD;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bp_data_r9", 64'(ReadData[0]), 64'hABCD);
        chk("bp_busy_r9", 64'(ReadBusy[0]), 64'd0);
`else
        chk("nobp_data_r9", 64'(ReadData[0]), 64'h1234);
        chk("nobp_busy_r9", 64'(ReadBusy[0]), 64'd1);
`endif
        chk("bp_data_r0", 64'(ReadData[1]), 64'd0);
        tick();
        idle();
        #1;
        chk("post_bp_data_r9", 64'(ReadData[0]), 64'hABCD);
        chk("post_bp_busy_r9", 64'(ReadBusy[0]), 64'd0);
        chk("post_bp_count", 64'(BusyCount), 64'd1);

        // Make r5 busy, then reset asynchronously mid-cycle
        IssueEn = 1'b1; IssueAddr = 5'd5;
        tick();
        idle();
        ReadAddr[0] = 5'd5; ReadAddr[1] = 5'd10;
        #1;
        chk("pre_rst_r5", 64'(ReadData[0]), 64'd50);
        chk("pre_rst_busy", 64'(ReadBusy[0]), 64'd1);
        chk("pre_rst_count", 64'(BusyCount), 64'd2);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_r5", 64'(ReadData[0]), 64'd0);
        chk("arst_r10", 64'(ReadData[1]), 64'd0);
        chk("arst_busy", 64'(ReadBusy[0]), 64'd0);
        chk("arst_count", 64'(BusyCount), 64'd0);

        // Write and issue while reset is held: lost
        WriteEn = 2'b01; WriteAddr[0] = 5'd5; WriteData[0] = 32'h77;
        IssueEn = 1'b1;  IssueAddr = 5'd5;
        tick();
        idle();
        #1;
        chk("held_rst_r5", 64'(ReadData[0]), 64'd0);
        chk("held_rst_count", 64'(BusyCount), 64'd0);

        // First functional edge after release
        @(negedge clk);
        rstn = 1'b1;
        WriteEn = 2'b10; WriteAddr[1] = 5'd5; WriteData[1] = 32'h99;
        tick();
        idle();
        #1;
        chk("post_rst_r5", 64'(ReadData[0]), 64'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-port integer register file for the RISC-V core. It generalises the fixed 32×32, two-read/one-write file to configurable width, depth and port counts. It hardwires register 0 and adds a per-register pending-write scoreboard, so decode can detect RAW hazards on in-flight destinations. Sits between decode (read/issue) and writeback (write/clear).

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- ReadAddr  in  NRD×AW  read addresses
- ReadData  out  NRD×XLEN  read data, combinational
- ReadBusy  out  NRD  addressed register has a pending write
- WriteEn  in  NWR  per-port write enable
- WriteAddr  in  NWR×AW  write addresses
- WriteData  in  NWR×XLEN  write data
- IssueEn  in  1  mark IssueAddr as pending-write
- IssueAddr  in  AW  destination register of issued instruction
- BusyCount  out  AW+1  number of registers currently pending

## Operation
- Reset: all registers = 0, all busy bits = 0, BusyCount = 0. ReadData/ReadBusy follow from the cleared state.
- Register 0:
  - always reads 0 and never reports busy
  - writes and issues to it are ignored, with no BusyCount change
- Write: on a rising edge, each port with WriteEn=1 stores WriteData at WriteAddr.
- Same-address conflict between write ports: the higher port index wins.
- Scoreboard, per register, at the rising edge:
  - IssueEn sets the busy bit
  - any enabled write clears the busy bit
  - issue and write to the same register in the same cycle: busy stays set (a newer producer is pending)
- Issue to an already-busy register: the bit stays set; BusyCount is unchanged.
- BusyCount is a registered population count. It is updated incrementally: +1 for each bit newly set, −1 for each bit newly cleared, computed from the next-state vector. It never wraps (maximum NREGS−1).
- ReadBusy[i] = busy[ReadAddr[i]], subject to the bypass rules below.

## Timing
- Read latency 0: ReadData is combinational from ReadAddr and the array.
- A write becomes architecturally visible one cycle after the edge, or the same cycle when bypass is enabled.
- Scoreboard changes are visible on ReadBusy and BusyCount after the edge.
- An asynchronous reset asserted mid-operation clears the array, scoreboard and count immediately. Writes/issues in that cycle are lost.
- The first edge after rstn deasserts is the first functional edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - a read address matching an enabled same-cycle write returns that WriteData (highest-index matching port) and ReadBusy=0 for it
  - address 0 is never bypassed
- REGFILE_BYPASS_EN undefined:
  - reads return the pre-edge stored value
  - ReadBusy reflects the pre-edge busy bit
  - decode must stall one extra cycle

## Structure
- Package regfile_pkg holds:
  - defaults XLEN_DEF, NREGS_DEF
  - a typedef for the register address
  - a function returning the highest-priority matching write port (shared by array write and bypass)
- Sub-module regfile_scoreboard holds the busy vector, set/clear logic and BusyCount.
- The data array and read muxes stay in the top.

## Test plan
- Reset then read all addresses -> ReadData=0, ReadBusy=0, BusyCount=0.
- Write 50 to r5 via port 0 and 30 to r10 via port 1 in one cycle; next cycle read r5/r10 -> 50/30.
- Port 0 writes 0x11 and port 1 writes 0x22 to r7 in the same cycle -> r7 reads 0x22. Write 0xFF to r0 -> r0 reads 0.
- Issue r3, r4 on consecutive cycles -> BusyCount=2, ReadBusy on r3=1. Then write r3 together with issue r3 -> busy stays 1, BusyCount=2. Then write r4 alone -> BusyCount=1.
- With REGFILE_BYPASS_EN: write 0xABCD to r9 while reading r9 -> same-cycle ReadData=0xABCD, ReadBusy=0. Without the macro -> old value returned.
- Assert rstn=0 mid-cycle with r5=50 and r5 busy -> r5 reads 0 and BusyCount=0 immediately.
